// File: rtl/fifo_umbrales_pkg.sv
// Shared definitions for the thresholded queue FIFOs.
//   - Default geometry of each queue (word width, address width).
//   - Bit positions of each queue inside the control machine's
//     FIFO_empties / FIFO_errors vectors.
package fifo_umbrales_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 2;

  localparam int IDX_MF  = 0;
  localparam int IDX_VC0 = 1;
  localparam int IDX_VC1 = 2;
  localparam int IDX_D0  = 3;
  localparam int IDX_D1  = 4;

  localparam int NUM_FIFOS = 5;

endpackage

// File: rtl/fifo_umbrales_memoria_dp.sv
// memoria_dp: 2**ADDR_WIDTH x DATA_WIDTH register file.
//   clk      in   single clock
//   reset    in   synchronous active-high; clears only the read register
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data only changes when this is high
//   rd_addr  in   read address
//   rd_data  out  registered read data
// Reading and writing the same address on one edge returns the old word.
module memoria_dp
  import fifo_umbrales_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is never cleared; the owner makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: synchronous FIFO with programmable almost-full /
// almost-empty thresholds, one instance per queue feeding the control
// machine.
//   clk           in   single clock
//   reset         in   synchronous, active-high; flushes the queue
//   push          in   write request
//   data_in       in   write data, sampled with push
//   pop           in   read request
//   umbral_alto   in   almost-full threshold
//   umbral_bajo   in   almost-empty threshold
//   data_out      out  registered read data (holds when no pop)
//   valid_out     out  data_out was popped on the previous edge
//   fifo_empty    out  occupancy == 0
//   fifo_full     out  occupancy == depth
//   almost_full   out  occupancy >= umbral_alto
//   almost_empty  out  occupancy <= umbral_bajo
//   fifo_error    out  sticky overflow/underflow indication
module fifo_umbrales
  import fifo_umbrales_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  vld_p1;
  logic                  err_q;

  logic pop_acc;
  logic push_acc;
  logic overflow;
  logic underflow;

  // Flags derive from the registered count only; thresholds are
  // zero-extended so a threshold of 0 makes almost_full constant 1.
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == COUNT_FULL);
  assign almost_full  = (count >= {1'b0, umbral_alto});
  assign almost_empty = (count <= {1'b0, umbral_bajo});

  // A full queue still takes a push when a pop frees a slot the same
  // edge; an empty queue never forwards a same-cycle push to the reader.
  assign pop_acc   = pop && !fifo_empty;
  assign push_acc  = push && (!fifo_full || pop_acc);
  assign overflow  = push && fifo_full && !pop;
  assign underflow = pop && fifo_empty;

  // ---- stage p0 -> p1: pointer/count/status update, registered read ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      vld_p1 <= pop_acc;
      if (overflow || underflow) err_q <= 1'b1;
    end
  end

  memoria_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc && !reset),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_acc && !reset),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  assign valid_out  = vld_p1;
  assign fifo_error = err_q;

endmodule

// File: tb/tb_fifo_umbrales.sv
module tb_fifo_umbrales;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] umbral_alto = 2'd3;
  logic [AW-1:0] umbral_bajo = 2'd1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic          almost_full;
  logic          almost_empty;
  logic          fifo_error;

  fifo_umbrales #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: queue contents plus the registered outputs.
  int            q[$];
  logic          m_err   = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_dout  = '0;
  bit            chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, return
  // just after the edge so outputs are settled.
  task automatic cycle(input logic r, input logic p, input logic po, input logic [DW-1:0] d);
    bit was_full, was_empty, do_pop, do_push;
    reset = r; push = p; pop = po; data_in = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_err = 1'b0; m_valid = 1'b0; m_dout = '0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      do_pop  = po && !was_empty;
      do_push = p && (!was_full || do_pop);
      if (do_pop) begin
        m_dout  = DW'(q.pop_front());
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (do_push) q.push_back(int'(d));
      if ((p && was_full && !po) || (po && was_empty)) m_err = 1'b1;
    end
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out",     32'(data_out),     32'(m_dout));
      check("valid_out",    32'(valid_out),    32'(m_valid));
      check("fifo_empty",   32'(fifo_empty),   32'(q.size() == 0));
      check("fifo_full",    32'(fifo_full),    32'(q.size() == DEPTH));
      check("almost_full",  32'(almost_full),  32'(q.size() >= int'(umbral_alto)));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= int'(umbral_bajo)));
      check("fifo_error",   32'(fifo_error),   32'(m_err));
    end
  end

  initial begin
    // Reset state
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk_en = 1'b1;
    check("rst_empty",     32'(fifo_empty),   32'd1);
    check("rst_full",      32'(fifo_full),    32'd0);
    check("rst_aempty",    32'(almost_empty), 32'd1);
    check("rst_afull",     32'(almost_full),  32'd0);
    check("rst_error",     32'(fifo_error),   32'd0);
    check("rst_valid",     32'(valid_out),    32'd0);
    check("rst_data",      32'(data_out),     32'd0);

    // 1. Four pushes with alto=3, bajo=1
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, 0, DW'(i));
      check("t1_aempty", 32'(almost_empty), (i < 2) ? 32'd1 : 32'd0);
      check("t1_afull",  32'(almost_full),  (i >= 3) ? 32'd1 : 32'd0);
      check("t1_full",   32'(fifo_full),    (i == 4) ? 32'd1 : 32'd0);
      check("t1_error",  32'(fifo_error),   32'd0);
    end

    // 2. Overflow, then drain in order
    cycle(0, 1, 0, 6'h3F);
    check("t2_full",  32'(fifo_full),  32'd1);
    check("t2_error", 32'(fifo_error), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 1, 0);
      check("t2_data",  32'(data_out),   32'(i));
      check("t2_valid", 32'(valid_out),  32'd1);
      check("t2_error", 32'(fifo_error), 32'd1);
    end
    check("t2_empty", 32'(fifo_empty), 32'd1);

    // 3. Underflow, push+pop on empty, then pop
    cycle(0, 0, 1, 0);
    check("t3_valid", 32'(valid_out),  32'd0);
    check("t3_error", 32'(fifo_error), 32'd1);
    check("t3_empty", 32'(fifo_empty), 32'd1);
    cycle(0, 1, 1, 6'h2A);
    check("t3_empty2", 32'(fifo_empty),   32'd0);
    check("t3_valid2", 32'(valid_out),    32'd0);
    check("t3_aempty", 32'(almost_empty), 32'd1);
    cycle(0, 0, 1, 0);
    check("t3_data",  32'(data_out),  32'h2A);
    check("t3_valid3", 32'(valid_out), 32'd1);

    // 4. Full, simultaneous push/pop across pointer wrap
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, DW'(8'h10 + i));
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 1, DW'(8'h20 + i));
      check("t4_data",  32'(data_out),  (i < 4) ? 32'(8'h10 + i) : 32'(8'h20 + i - 4));
      check("t4_valid", 32'(valid_out), 32'd1);
      check("t4_full",  32'(fifo_full), 32'd1);
    end
    check("t4_error", 32'(fifo_error), 32'd0);

    // 5. Reset with count=3 and push high, error previously set
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("t5_err_set", 32'(fifo_error), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, DW'(i + 5));
    cycle(0, 1, 1, 6'h11);
    cycle(1, 1, 0, 6'h15);
    check("t5_empty", 32'(fifo_empty), 32'd1);
    check("t5_error", 32'(fifo_error), 32'd0);
    check("t5_valid", 32'(valid_out),  32'd0);
    check("t5_afull", 32'(almost_full), 32'd0);

    // 6. Threshold sweep with count=2
    cycle(0, 1, 0, 6'h01);
    cycle(0, 1, 0, 6'h02);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        umbral_alto = AW'(a);
        umbral_bajo = AW'(b);
        #1;
        check("t6_afull",  32'(almost_full),  32'(2 >= a));
        check("t6_aempty", 32'(almost_empty), 32'(2 <= b));
        cycle(0, 0, 0, 0);
      end
    end
    umbral_alto = 2'd3;
    umbral_bajo = 2'd1;

    // Randomized traffic with occasional resets and threshold changes
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        umbral_alto = AW'($urandom_range(0, 3));
        umbral_bajo = AW'($urandom_range(0, 3));
      end
      cycle(($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), DW'($urandom));
    end

    cycle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
